addsub4_sweep: RTL and testbench

Self-checking operand sequencer that sits directly in front of and behind the 4-bit signed add/subtract stage (`addSub4`). On `start` it drives every combination of `op`, `a` and `b` into the adder, waits a programmable settle time, and samples the adder's `sum`/`c_out`. It compares `sum` against an internally computed expected value and reports an error count, the first failing vector, and a done flag. It replaces the free-running, hand-edited stimulus around the adder with a synthesizable, cycle-deterministic checker.

---
 rtl/addsub4_sweep.sv | 134 +++++++++++++
 tb/tb_addsub4_sweep.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub4_sweep.sv
// Exhaustive operand sequencer and result checker for the 4-bit signed add/subtract stage.
// Walks all 512 {op,a,b} vectors, waits SETTLE_CYC cycles, and tallies mismatches.
module addsub4_sweep #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       op,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       c_in,
  input  logic [4:0] sum_in,
  input  logic       c_out_in,
  output logic       busy,
  output logic       done,
  output logic [9:0] err_cnt,
  output logic       first_err_valid,
  output logic [8:0] first_err_vec,
  output logic [4:0] last_sum,
  output logic       last_cout
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [8:0] vecIdx_q, vecIdx_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic [9:0] errCnt_q, errCnt_d;
  logic       firstErrValid_q, firstErrValid_d;
  logic [8:0] firstErrVec_q, firstErrVec_d;
  logic [4:0] lastSum_q, lastSum_d;
  logic       lastCout_q, lastCout_d;

  logic signed [4:0] aExt, bExt;
  logic        [4:0] expSum;

  assign aExt   = {vecIdx_q[7], vecIdx_q[7:4]};
  assign bExt   = {vecIdx_q[3], vecIdx_q[3:0]};
  assign expSum = vecIdx_q[8] ? 5'(aExt - bExt) : 5'(aExt + bExt);

  always_comb begin
    state_d         = state_q;
    vecIdx_d        = vecIdx_q;
    waitCnt_d       = waitCnt_q;
    errCnt_d        = errCnt_q;
    firstErrValid_d = firstErrValid_q;
    firstErrVec_d   = firstErrVec_q;
    lastSum_d       = lastSum_q;
    lastCout_d      = lastCout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = DRIVE;
          vecIdx_d        = 9'd0;
          errCnt_d        = 10'd0;
          firstErrValid_d = 1'b0;
          firstErrVec_d   = 9'd0;
        end
      end
      DRIVE: begin
        if (SETTLE_CYC > 0) begin
          state_d   = WAIT;
          waitCnt_d = WAIT_LOAD;
        end else begin
          state_d = CHECK;
        end
      end
      WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      CHECK: begin
        lastSum_d  = sum_in;
        lastCout_d = c_out_in;
        // The very first mismatch of a sweep is latched and never overwritten.
        if (sum_in != expSum) begin
          errCnt_d = errCnt_q + 10'd1;
          if (!firstErrValid_q) begin
            firstErrValid_d = 1'b1;
            firstErrVec_d   = vecIdx_q;
          end
        end
        if (vecIdx_q == 9'd511) begin
          state_d = DONE;
        end else begin
          vecIdx_d = vecIdx_q + 9'd1;
          state_d  = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      vecIdx_q        <= 9'd0;
      waitCnt_q       <= 4'd0;
      errCnt_q        <= 10'd0;
      firstErrValid_q <= 1'b0;
      firstErrVec_q   <= 9'd0;
      lastSum_q       <= 5'd0;
      lastCout_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      vecIdx_q        <= vecIdx_d;
      waitCnt_q       <= waitCnt_d;
      errCnt_q        <= errCnt_d;
      firstErrValid_q <= firstErrValid_d;
      firstErrVec_q   <= firstErrVec_d;
      lastSum_q       <= lastSum_d;
      lastCout_q      <= lastCout_d;
    end
  end

  assign op              = vecIdx_q[8];
  assign a               = vecIdx_q[7:4];
  assign b               = vecIdx_q[3:0];
  assign c_in            = 1'b0;
  assign busy            = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign done            = (state_q == DONE);
  assign err_cnt         = errCnt_q;
  assign first_err_valid = firstErrValid_q;
  assign first_err_vec   = firstErrVec_q;
  assign last_sum        = lastSum_q;
  assign last_cout       = lastCout_q;

endmodule

// File: tb/tb_addsub4_sweep.sv
// Directed bench for addsub4_sweep: a behavioural adder (optionally faulty) closes the loop,
// and sweep timing, error tallies and reset behaviour are compared against hand-derived values.
module tb_addsub4_sweep;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start0;
  logic       op, c_in, c_out_in, busy, done, first_err_valid, last_cout;
  logic [3:0] a, b;
  logic [4:0] sum_in, last_sum;
  logic [9:0] err_cnt;
  logic [8:0] first_err_vec;
  logic       op0, c_in0, c_out_in0, busy0, done0, first_err_valid0, last_cout0;
  logic [3:0] a0, b0;
  logic [4:0] sum_in0, last_sum0;
  logic [9:0] err_cnt0;
  logic [8:0] first_err_vec0;

  int faultMode;
  int numChecks;
  int numErrors;

  always #5 clk = ~clk;

  // faultMode: 0 ideal, 1 sum bit 0 stuck low, 2 adder always adds regardless of op.
  function automatic logic [4:0] adderModel(input logic o, input logic [3:0] x, input logic [3:0] y,
                                            input int fm);
    logic signed [4:0] xs, ys, r;
    logic oe;
    oe = (fm == 2) ? 1'b0 : o;
    xs = {x[3], x};
    ys = {y[3], y};
    r  = oe ? xs - ys : xs + ys;
    if (fm == 1) r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic coutModel(input logic o, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, (o ? ~y : y)} + {4'd0, o};
    return t[4];
  endfunction

  assign sum_in    = adderModel(op, a, b, faultMode);
  assign c_out_in  = coutModel(op, a, b);
  assign sum_in0   = adderModel(op0, a0, b0, 0);
  assign c_out_in0 = coutModel(op0, a0, b0);

  addsub4_sweep #(.SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .c_in(c_in),
    .sum_in(sum_in), .c_out_in(c_out_in), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec),
    .last_sum(last_sum), .last_cout(last_cout)
  );

  addsub4_sweep #(.SETTLE_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .a(a0), .b(b0), .c_in(c_in0),
    .sum_in(sum_in0), .c_out_in(c_out_in0), .busy(busy0), .done(done0), .err_cnt(err_cnt0),
    .first_err_valid(first_err_valid0), .first_err_vec(first_err_vec0),
    .last_sum(last_sum0), .last_cout(last_cout0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    numChecks++;
    if (got !== want) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".vec"}, {23'd0, op, a, b}, 32'd0);
    checkOutput({tag, ".c_in"}, {31'd0, c_in}, 32'd0);
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".err_cnt"}, {22'd0, err_cnt}, 32'd0);
    checkOutput({tag, ".fev"}, {31'd0, first_err_valid}, 32'd0);
    checkOutput({tag, ".fevec"}, {23'd0, first_err_vec}, 32'd0);
    checkOutput({tag, ".last_sum"}, {27'd0, last_sum}, 32'd0);
    checkOutput({tag, ".last_cout"}, {31'd0, last_cout}, 32'd0);
  endtask

  // Pulses start, then counts cycles from the accepting edge until done; optionally re-pulses
  // start when the vector index reaches pulseIdx and verifies the index only ever steps by one.
  task automatic applyStimulus(input int pulseIdx, input bit checkClear, output int cycles);
    int prevIdx, curIdx, seqErrs;
    bit pulsed;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cycles  = 0;
    prevIdx = 0;
    seqErrs = 0;
    pulsed  = 1'b0;
    checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
    if (checkClear) begin
      checkOutput("restartErrCnt", {22'd0, err_cnt}, 32'd0);
      checkOutput("restartFev", {31'd0, first_err_valid}, 32'd0);
    end
    while (!done && cycles < 3000) begin
      start = 1'b0;
      if (pulseIdx >= 0 && !pulsed && {op, a, b} == 9'(pulseIdx)) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk);
      #1;
      cycles++;
      curIdx = int'({op, a, b});
      if (curIdx != prevIdx && curIdx != prevIdx + 1) seqErrs++;
      prevIdx = curIdx;
    end
    start = 1'b0;
    checkOutput("doneReached", {31'd0, done}, 32'd1);
    checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
    checkOutput("indexSequence", seqErrs, 32'd0);
  endtask

  initial begin
    int cycles;
    int guard;
    numChecks = 0;
    numErrors = 0;
    faultMode = 0;
    start     = 1'b0;
    start0    = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ideal sweep, settle 1");
    applyStimulus(-1, 1'b0, cycles);
    checkOutput("idealCycles", cycles, 32'd1536);
    checkOutput("idealErrCnt", {22'd0, err_cnt}, 32'd0);
    checkOutput("idealFev", {31'd0, first_err_valid}, 32'd0);
    checkOutput("idealLastSum", {27'd0, last_sum}, {27'd0, adderModel(1'b1, 4'hF, 4'hF, 0)});
    checkOutput("idealLastCout", {31'd0, last_cout}, {31'd0, coutModel(1'b1, 4'hF, 4'hF)});
    checkOutput("cInZero", {31'd0, c_in}, 32'd0);

    $display("[TB] start pulsed while busy at vector 100");
    applyStimulus(100, 1'b0, cycles);
    checkOutput("busyStartCycles", cycles, 32'd1536);
    checkOutput("busyStartErrCnt", {22'd0, err_cnt}, 32'd0);

    $display("[TB] sum bit 0 stuck low");
    faultMode = 1;
    applyStimulus(-1, 1'b0, cycles);
    checkOutput("stuckErrCnt", {22'd0, err_cnt}, 32'd256);
    checkOutput("stuckFev", {31'd0, first_err_valid}, 32'd1);
    checkOutput("stuckFevVec", {23'd0, first_err_vec}, 32'h001);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stuckStableErr", {22'd0, err_cnt}, 32'd256);
    checkOutput("stuckStableDone", {31'd0, done}, 32'd1);

    $display("[TB] restart from done with ideal adder");
    faultMode = 0;
    applyStimulus(-1, 1'b1, cycles);
    checkOutput("restartCycles", cycles, 32'd1536);
    checkOutput("restartFinalErr", {22'd0, err_cnt}, 32'd0);
    checkOutput("restartFinalFev", {31'd0, first_err_valid}, 32'd0);
    checkOutput("restartFinalVec", {23'd0, first_err_vec}, 32'd0);

    $display("[TB] adder ignores op");
    faultMode = 2;
    applyStimulus(-1, 1'b0, cycles);
    checkOutput("opErrCnt", {22'd0, err_cnt}, 32'd240);
    checkOutput("opFevVec", {23'd0, first_err_vec}, 32'h101);

    $display("[TB] reset mid-sweep at vector 300");
    faultMode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while ({op, a, b} != 9'd300 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("reachVec300", {23'd0, op, a, b}, 32'd300);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("noResumeBusy", {31'd0, busy}, 32'd0);
    checkOutput("noResumeVec", {23'd0, op, a, b}, 32'd0);
    checkOutput("noResumeDone", {31'd0, done}, 32'd0);
    faultMode = 0;

    $display("[TB] settle 0 instance");
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    cycles = 0;
    while (!done0 && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("settle0Cycles", cycles, 32'd1024);
    checkOutput("settle0ErrCnt", {22'd0, err_cnt0}, 32'd0);
    checkOutput("settle0Fev", {31'd0, first_err_valid0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numErrors);
    $finish;
  end

endmodule
